// File: rtl/fast_vram_slot_sched_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fast_vram_slot_sched_pkg
// Purpose  : Shared types and constants for the fast (upper) sprite VRAM
//            slot scheduler: slot-phase and parse-state encodings, address
//            region bases and the active-list address builder.
// Ports    : none (package)
// Revision : 1.0  initial release
// ============================================================================
package fast_vram_slot_sched_pkg;

  // Slot phase within a 4-slot frame.
  typedef enum logic [1:0] {
    PH_RENDER = 2'd0,
    PH_ACTRD  = 2'd1,
    PH_PARSE  = 2'd2,
    PH_CPU    = 2'd3
  } phase_e;

  // Per-line parse engine state.
  typedef enum logic [1:0] {
    PS_IDLE  = 2'd0,
    PS_READ  = 2'd1,
    PS_EVAL  = 2'd2,
    PS_WRITE = 2'd3
  } parse_state_e;

  localparam logic [1:0] SCB3_BASE    = 2'b01;   // Y/size table, 0x200..
  localparam logic [2:0] ACTLIST_BASE = 3'b110;  // active list, 0x600..

  // Active-list word address: two 128-entry banks at 0x600 / 0x680.
  function automatic logic [10:0] actlist_addr(input logic bank, input logic [6:0] ptr);
    return {ACTLIST_BASE, bank, ptr};
  endfunction

endpackage
`default_nettype wire

// File: rtl/fast_vram_slot_sched_if.sv
`default_nettype none
// ============================================================================
// Module   : fast_vram_slot_sched_if
// Purpose  : CPU request/acknowledge handshake and fast-VRAM port bus.
// Signals  : cpu_req/cpu_we/cpu_addr/cpu_wdata  CPU access request (level)
//            cpu_ack                            one-CLK completion pulse
//            fvram_addr/fvram_data_out/cwe      VRAM address, write data,
//                                               active-low write enable
// Modports : slave  - the scheduler
//            master - the CPU / VRAM side
// Revision : 1.0  initial release
// ============================================================================
interface fast_vram_slot_sched_if;
  logic        cpu_req;
  logic        cpu_we;
  logic [10:0] cpu_addr;
  logic [15:0] cpu_wdata;
  logic        cpu_ack;
  logic [10:0] fvram_addr;
  logic [15:0] fvram_data_out;
  logic        cwe;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_ack, fvram_addr, fvram_data_out, cwe
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_ack, fvram_addr, fvram_data_out, cwe
  );
endinterface
`default_nettype wire

// File: rtl/fast_vram_slot_sched_parse_fsm.sv
`default_nettype none
// ============================================================================
// Module   : fast_vram_slot_sched_parse_fsm
// Purpose  : Per-line parse engine. Walks sprite indices 0..PARSE_LAST,
//            reading each Y entry in the parse slot, and appends matching
//            indices to the active-list write bank until it is full.
// Ports    : clk, rst         clock, synchronous active-high reset
//            new_line_i       restart parse for a new line
//            slot_i           a parse-phase slot is starting this CLK
//            rvalid_i         parse read data valid, match_i sampled
//            match_i          Y-match result for the last read
//            flip_i           active-list write bank
//            acc_o/we_o       access request for this slot / is a write
//            addr_o/data_o    address and write data for the request
//            done_o           parse finished or list full
//            count_o          entries written this line
// Revision : 1.0  initial release
// ============================================================================
module fast_vram_slot_sched_parse_fsm
  import fast_vram_slot_sched_pkg::*;
#(
  parameter logic [8:0] PARSE_LAST = 9'd380,
  parameter logic [6:0] ACTIVE_MAX = 7'd96
) (
  input  wire logic        clk,
  input  wire logic        rst,
  input  wire logic        new_line_i,
  input  wire logic        slot_i,
  input  wire logic        rvalid_i,
  input  wire logic        match_i,
  input  wire logic        flip_i,
  output logic             acc_o,
  output logic             we_o,
  output logic [10:0]      addr_o,
  output logic [15:0]      data_o,
  output logic             done_o,
  output logic [6:0]       count_o
);

  parse_state_e state_q, state_d;
  logic [8:0]   idx_q, idx_d;
  logic [6:0]   wr_q, wr_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= PS_IDLE;
      idx_q   <= '0;
      wr_q    <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      wr_q    <= wr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    wr_d    = wr_q;
    acc_o   = 1'b0;
    we_o    = 1'b0;
    addr_o  = {SCB3_BASE, idx_q};
    data_o  = {7'b0, idx_q};
    // A new line abandons any read in flight or pending write, and also
    // suppresses the access of a parse slot starting in the same CLK.
    if (new_line_i) begin
      state_d = PS_READ;
      idx_d   = '0;
      wr_d    = '0;
    end else begin
      case (state_q)
        PS_READ: begin
          if (slot_i) begin
            acc_o   = 1'b1;
            state_d = PS_EVAL;
          end
        end
        PS_EVAL: begin
          if (rvalid_i) begin
            if (match_i) begin
              state_d = PS_WRITE;
            end else begin
              idx_d   = idx_q + 9'd1;
              state_d = (idx_q == PARSE_LAST) ? PS_IDLE : PS_READ;
            end
          end
        end
        PS_WRITE: begin
          if (slot_i) begin
            acc_o   = 1'b1;
            we_o    = 1'b1;
            addr_o  = actlist_addr(flip_i, wr_q);
            idx_d   = idx_q + 9'd1;
            wr_d    = wr_q + 7'd1;
            state_d = ((idx_q == PARSE_LAST) || (wr_q + 7'd1 == ACTIVE_MAX)) ? PS_IDLE : PS_READ;
          end
        end
        default: ;
      endcase
    end
  end

  assign done_o  = (state_q == PS_IDLE);
  assign count_o = wr_q;

endmodule
`default_nettype wire

// File: rtl/fast_vram_slot_sched.sv
`default_nettype none
// ============================================================================
// Module   : fast_vram_slot_sched
// Purpose  : Time-slot scheduler for the 2K x 16 fast sprite VRAM. Each
//            4-slot frame grants the single port to render read, active-list
//            read, parse read / active-list write and CPU access.
// Ports    : clk, rst          clock, synchronous active-high reset
//            slot_en_i         one-CLK pulse per VRAM slot
//            new_line_i        restart parse for the next line
//            flip_i            active-list bank select (write=flip, read=~flip)
//            reload_rd_i       clear active-list read counter
//            render_spr_i/tbl_i render read sprite number / table
//            parse_match_i     Y-match for last parse read
//            bus               CPU handshake + VRAM address/data/CWE
//            render_rvalid_o, actrd_rvalid_o, parse_rvalid_o  read strobes
//            parse_done_o, active_count_o  parse status
// Revision : 1.0  initial release
// ============================================================================
module fast_vram_slot_sched
  import fast_vram_slot_sched_pkg::*;
#(
  parameter logic [8:0] PARSE_LAST = 9'd380,
  parameter logic [6:0] ACTIVE_MAX = 7'd96
) (
  input  wire logic              clk,
  input  wire logic              rst,
  input  wire logic              slot_en_i,
  input  wire logic              new_line_i,
  input  wire logic              flip_i,
  input  wire logic              reload_rd_i,
  input  wire logic [8:0]        render_spr_i,
  input  wire logic [1:0]        render_tbl_i,
  input  wire logic              parse_match_i,
  fast_vram_slot_sched_if.slave  bus,
  output logic                   render_rvalid_o,
  output logic                   actrd_rvalid_o,
  output logic                   parse_rvalid_o,
  output logic                   parse_done_o,
  output logic [6:0]             active_count_o
);

  phase_e      phase_q, phase_d;
  logic [6:0]  rd_q, rd_d;
  logic [10:0] addr_q, addr_d;
  logic [15:0] data_q, data_d;
  logic        cwe_q, cwe_d;
  // Which read (if any) was issued in the slot now running; the matching
  // strobe fires on the SLOT_EN that ends it, when its data is on the bus.
  logic        render_pend_q, render_pend_d;
  logic        actrd_pend_q, actrd_pend_d;
  logic        parse_pend_q, parse_pend_d;
  logic        cpu_pend_q, cpu_pend_d;

  logic        p_acc, p_we;
  logic [10:0] p_addr;
  logic [15:0] p_data;

  fast_vram_slot_sched_parse_fsm #(
    .PARSE_LAST (PARSE_LAST),
    .ACTIVE_MAX (ACTIVE_MAX)
  ) u_parse (
    .clk        (clk),
    .rst        (rst),
    .new_line_i (new_line_i),
    .slot_i     (slot_en_i && (phase_q == PH_PARSE)),
    .rvalid_i   (parse_rvalid_o),
    .match_i    (parse_match_i),
    .flip_i     (flip_i),
    .acc_o      (p_acc),
    .we_o       (p_we),
    .addr_o     (p_addr),
    .data_o     (p_data),
    .done_o     (parse_done_o),
    .count_o    (active_count_o)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      phase_q       <= PH_RENDER;
      rd_q          <= '0;
      addr_q        <= '0;
      data_q        <= '0;
      cwe_q         <= 1'b1;
      render_pend_q <= 1'b0;
      actrd_pend_q  <= 1'b0;
      parse_pend_q  <= 1'b0;
      cpu_pend_q    <= 1'b0;
    end else begin
      phase_q       <= phase_d;
      rd_q          <= rd_d;
      addr_q        <= addr_d;
      data_q        <= data_d;
      cwe_q         <= cwe_d;
      render_pend_q <= render_pend_d;
      actrd_pend_q  <= actrd_pend_d;
      parse_pend_q  <= parse_pend_d;
      cpu_pend_q    <= cpu_pend_d;
    end
  end

  always_comb begin
    phase_d       = phase_q;
    rd_d          = rd_q;
    addr_d        = addr_q;
    data_d        = data_q;
    cwe_d         = cwe_q;
    render_pend_d = render_pend_q;
    actrd_pend_d  = actrd_pend_q;
    parse_pend_d  = parse_pend_q;
    cpu_pend_d    = cpu_pend_q;
    if (slot_en_i) begin
      phase_d       = phase_e'(phase_q + 2'd1);
      cwe_d         = 1'b1;
      render_pend_d = 1'b0;
      actrd_pend_d  = 1'b0;
      parse_pend_d  = 1'b0;
      cpu_pend_d    = 1'b0;
      case (phase_q)
        PH_RENDER: begin
          addr_d        = {render_tbl_i, render_spr_i};
          render_pend_d = 1'b1;
        end
        PH_ACTRD: begin
          addr_d       = actlist_addr(~flip_i, rd_q);
          actrd_pend_d = 1'b1;
          rd_d         = rd_q + 7'd1;
        end
        PH_PARSE: begin
          if (p_acc) begin
            addr_d = p_addr;
            if (p_we) begin
              cwe_d  = 1'b0;
              data_d = p_data;
            end else begin
              parse_pend_d = 1'b1;
            end
          end
        end
        PH_CPU: begin
          if (bus.cpu_req) begin
            addr_d     = bus.cpu_addr;
            cpu_pend_d = 1'b1;
            if (bus.cpu_we) begin
              cwe_d  = 1'b0;
              data_d = bus.cpu_wdata;
            end
          end
        end
        default: ;
      endcase
    end
    if (reload_rd_i) begin
      rd_d = '0;
    end
  end

  assign bus.fvram_addr     = addr_q;
  assign bus.fvram_data_out = data_q;
  assign bus.cwe            = cwe_q;
  assign bus.cpu_ack        = slot_en_i & cpu_pend_q;
  assign render_rvalid_o    = slot_en_i & render_pend_q;
  assign actrd_rvalid_o     = slot_en_i & actrd_pend_q;
  assign parse_rvalid_o     = slot_en_i & parse_pend_q;

endmodule
`default_nettype wire

// File: tb/tb_fast_vram_slot_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_fast_vram_slot_sched
// Purpose  : Directed self-checking bench for fast_vram_slot_sched.
// Revision : 1.0  initial release
// ============================================================================
module tb_fast_vram_slot_sched;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       slot_en = 1'b0;
  logic       new_line = 1'b0;
  logic       flip = 1'b0;
  logic       reload_rd = 1'b0;
  logic [8:0] render_spr = 9'h05A;
  logic [1:0] render_tbl = 2'd1;
  logic       parse_match = 1'b0;
  logic       render_rvalid, actrd_rvalid, parse_rvalid, parse_done;
  logic [6:0] active_count;

  fast_vram_slot_sched_if bus ();

  fast_vram_slot_sched dut (
    .clk             (clk),
    .rst             (rst),
    .slot_en_i       (slot_en),
    .new_line_i      (new_line),
    .flip_i          (flip),
    .reload_rd_i     (reload_rd),
    .render_spr_i    (render_spr),
    .render_tbl_i    (render_tbl),
    .parse_match_i   (parse_match),
    .bus             (bus),
    .render_rvalid_o (render_rvalid),
    .actrd_rvalid_o  (actrd_rvalid),
    .parse_rvalid_o  (parse_rvalid),
    .parse_done_o    (parse_done),
    .active_count_o  (active_count)
  );

  always #5 clk = ~clk;

  int          n_cmp = 0;
  int          n_bad = 0;
  int          ph = 0;               // phase of the next slot to start
  logic [10:0] s_addr = '0;
  logic [10:0] prev_addr = '0;
  logic [15:0] s_data;
  logic        s_cwe;
  logic        s_rr, s_ar, s_pr, s_ack;

  // One slot: SLOT_EN high one CLK (strobes sampled then), outputs of the
  // new slot sampled on the following falling edge, then two idle CLKs.
  task automatic do_slot(input bit nl);
    @(negedge clk);
    slot_en  = 1'b1;
    new_line = nl;
    #1;
    s_rr  = render_rvalid;
    s_ar  = actrd_rvalid;
    s_pr  = parse_rvalid;
    s_ack = bus.cpu_ack;
    @(negedge clk);
    slot_en   = 1'b0;
    new_line  = 1'b0;
    prev_addr = s_addr;
    s_addr    = bus.fvram_addr;
    s_data    = bus.fvram_data_out;
    s_cwe     = bus.cwe;
    ph        = (ph + 1) % 4;
    @(negedge clk);
  endtask

  task automatic pulse_nl();
    @(negedge clk); new_line = 1'b1;
    @(negedge clk); new_line = 1'b0;
  endtask

  task automatic align_p0();
    while (ph != 0) do_slot(1'b0);
  endtask

  task automatic test_reset();
    logic [10:0] exp_a;
    logic [3:0]  exp_s;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    ph = 0;
    #1;
    n_cmp++; if (bus.fvram_addr !== 11'h000) begin n_bad++; $display("FAIL reset_addr got=%h exp=000", bus.fvram_addr); end
    n_cmp++; if (bus.fvram_data_out !== 16'h0000) begin n_bad++; $display("FAIL reset_data got=%h exp=0000", bus.fvram_data_out); end
    n_cmp++; if (bus.cwe !== 1'b1) begin n_bad++; $display("FAIL reset_cwe got=%b exp=1", bus.cwe); end
    n_cmp++; if (parse_done !== 1'b1) begin n_bad++; $display("FAIL reset_done got=%b exp=1", parse_done); end
    n_cmp++; if (active_count !== 7'd0) begin n_bad++; $display("FAIL reset_count got=%0d exp=0", active_count); end
    n_cmp++; if ({render_rvalid, actrd_rvalid, parse_rvalid, bus.cpu_ack} !== 4'b0000) begin
      n_bad++; $display("FAIL reset_strobes got=%b exp=0000", {render_rvalid, actrd_rvalid, parse_rvalid, bus.cpu_ack}); end
    exp_a = 11'h000;
    for (int k = 0; k < 8; k++) begin
      do_slot(1'b0);
      case (k % 4)
        0: exp_a = 11'h25A;
        1: exp_a = 11'(32'h680 + k / 4);
        default: ;   // parse idle and no CPU request: address holds
      endcase
      n_cmp++; if (s_addr !== exp_a || s_cwe !== 1'b1 || parse_done !== 1'b1) begin
        n_bad++; $display("FAIL idle_slot%0d addr=%h cwe=%b done=%b exp addr=%h cwe=1 done=1", k, s_addr, s_cwe, parse_done, exp_a); end
      exp_s = {(k > 0) && ((k - 1) % 4 == 0), (k > 0) && ((k - 1) % 4 == 1), 2'b00};
      n_cmp++; if ({s_rr, s_ar, s_pr, s_ack} !== exp_s) begin
        n_bad++; $display("FAIL idle_strobes%0d got=%b exp=%b", k, {s_rr, s_ar, s_pr, s_ack}, exp_s); end
    end
  endtask

  task automatic test_parse_nomatch();
    parse_match = 1'b0;
    align_p0();
    pulse_nl();
    #1;
    n_cmp++; if (parse_done !== 1'b0) begin n_bad++; $display("FAIL nl_done got=%b exp=0", parse_done); end
    for (int f = 0; f <= 380; f++) begin
      do_slot(1'b0); do_slot(1'b0); do_slot(1'b0);
      n_cmp++; if (s_addr !== 11'(32'h200 + f) || s_cwe !== 1'b1) begin
        n_bad++; $display("FAIL nomatch_rd%0d addr=%h cwe=%b exp addr=%h cwe=1", f, s_addr, s_cwe, 11'(32'h200 + f)); end
      do_slot(1'b0);
      n_cmp++; if (s_pr !== 1'b1) begin n_bad++; $display("FAIL nomatch_rvalid%0d got=%b exp=1", f, s_pr); end
    end
    n_cmp++; if (parse_done !== 1'b1) begin n_bad++; $display("FAIL nomatch_done got=%b exp=1", parse_done); end
    n_cmp++; if (active_count !== 7'd0) begin n_bad++; $display("FAIL nomatch_count got=%0d exp=0", active_count); end
    do_slot(1'b0); do_slot(1'b0); do_slot(1'b0);
    n_cmp++; if (s_addr !== prev_addr || s_cwe !== 1'b1) begin
      n_bad++; $display("FAIL nomatch_idle addr=%h cwe=%b exp addr=%h cwe=1", s_addr, s_cwe, prev_addr); end
    do_slot(1'b0);
  endtask

  task automatic test_parse_match();
    parse_match = 1'b1;
    flip = 1'b0;
    align_p0();
    pulse_nl();
    for (int k = 0; k < 96; k++) begin
      do_slot(1'b0); do_slot(1'b0); do_slot(1'b0);
      n_cmp++; if (s_addr !== 11'(32'h200 + k) || s_cwe !== 1'b1) begin
        n_bad++; $display("FAIL match_rd%0d addr=%h cwe=%b exp addr=%h cwe=1", k, s_addr, s_cwe, 11'(32'h200 + k)); end
      do_slot(1'b0);
      do_slot(1'b0); do_slot(1'b0); do_slot(1'b0);
      n_cmp++; if (s_addr !== 11'(32'h600 + k) || s_cwe !== 1'b0 || s_data !== 16'(k)) begin
        n_bad++; $display("FAIL match_wr%0d addr=%h cwe=%b data=%h exp addr=%h cwe=0 data=%h", k, s_addr, s_cwe, s_data, 11'(32'h600 + k), 16'(k)); end
      do_slot(1'b0);
      n_cmp++; if (s_cwe !== 1'b1 || s_pr !== 1'b0) begin
        n_bad++; $display("FAIL match_after_wr%0d cwe=%b rvalid=%b exp cwe=1 rvalid=0", k, s_cwe, s_pr); end
    end
    n_cmp++; if (parse_done !== 1'b1) begin n_bad++; $display("FAIL match_done got=%b exp=1", parse_done); end
    n_cmp++; if (active_count !== 7'd96) begin n_bad++; $display("FAIL match_count got=%0d exp=96", active_count); end
    do_slot(1'b0); do_slot(1'b0); do_slot(1'b0);
    n_cmp++; if (s_addr !== prev_addr || s_cwe !== 1'b1) begin
      n_bad++; $display("FAIL full_idle addr=%h cwe=%b exp addr=%h cwe=1", s_addr, s_cwe, prev_addr); end
    do_slot(1'b0);
  endtask

  task automatic test_cpu_access();
    parse_match = 1'b0;
    flip = 1'b0;
    align_p0();
    pulse_nl();
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b1; bus.cpu_addr = 11'h123; bus.cpu_wdata = 16'hBEEF;
    for (int s = 0; s < 3; s++) begin
      do_slot(1'b0);
      n_cmp++; if (s_cwe !== 1'b1 || s_ack !== 1'b0) begin
        n_bad++; $display("FAIL cpuw_pre%0d cwe=%b ack=%b exp cwe=1 ack=0", s, s_cwe, s_ack); end
    end
    n_cmp++; if (s_addr !== 11'h200) begin n_bad++; $display("FAIL cpuw_parse0 addr=%h exp=200", s_addr); end
    do_slot(1'b0);
    n_cmp++; if (s_addr !== 11'h123 || s_cwe !== 1'b0 || s_data !== 16'hBEEF) begin
      n_bad++; $display("FAIL cpuw_slot addr=%h cwe=%b data=%h exp addr=123 cwe=0 data=beef", s_addr, s_cwe, s_data); end
    do_slot(1'b0);
    n_cmp++; if (s_ack !== 1'b1 || s_cwe !== 1'b1 || s_addr !== 11'h25A) begin
      n_bad++; $display("FAIL cpuw_ack ack=%b cwe=%b addr=%h exp ack=1 cwe=1 addr=25a", s_ack, s_cwe, s_addr); end
    bus.cpu_req = 1'b0;
    do_slot(1'b0);
    n_cmp++; if (s_ack !== 1'b0) begin n_bad++; $display("FAIL cpuw_ack_once got=%b exp=0", s_ack); end
    do_slot(1'b0);
    n_cmp++; if (s_addr !== 11'h201 || s_cwe !== 1'b1) begin
      n_bad++; $display("FAIL cpuw_parse1 addr=%h cwe=%b exp addr=201 cwe=1", s_addr, s_cwe); end
    do_slot(1'b0);
    n_cmp++; if (s_addr !== 11'h201 || s_cwe !== 1'b1) begin
      n_bad++; $display("FAIL cpu_noreq addr=%h cwe=%b exp addr=201 cwe=1", s_addr, s_cwe); end
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 11'h045;
    do_slot(1'b0); do_slot(1'b0); do_slot(1'b0);
    n_cmp++; if (s_addr !== 11'h202) begin n_bad++; $display("FAIL cpur_parse2 addr=%h exp=202", s_addr); end
    do_slot(1'b0);
    n_cmp++; if (s_addr !== 11'h045 || s_cwe !== 1'b1) begin
      n_bad++; $display("FAIL cpur_slot addr=%h cwe=%b exp addr=045 cwe=1", s_addr, s_cwe); end
    do_slot(1'b0);
    n_cmp++; if (s_ack !== 1'b1) begin n_bad++; $display("FAIL cpur_ack got=%b exp=1", s_ack); end
    bus.cpu_req = 1'b0;
  endtask

  task automatic test_actrd_wrap();
    flip = 1'b1;
    parse_match = 1'b1;
    align_p0();
    @(negedge clk); reload_rd = 1'b1;
    @(negedge clk); reload_rd = 1'b0;
    pulse_nl();
    for (int f = 0; f < 130; f++) begin
      do_slot(1'b0); do_slot(1'b0);
      n_cmp++; if (s_addr !== 11'(32'h600 + (f % 128)) || s_cwe !== 1'b1) begin
        n_bad++; $display("FAIL actrd%0d addr=%h cwe=%b exp addr=%h cwe=1", f, s_addr, s_cwe, 11'(32'h600 + (f % 128))); end
      do_slot(1'b0);
      if (f % 2 == 1) begin
        n_cmp++; if (s_addr !== 11'(32'h680 + f / 2) || s_cwe !== 1'b0 || s_data !== 16'(f / 2)) begin
          n_bad++; $display("FAIL flipwr%0d addr=%h cwe=%b data=%h exp addr=%h cwe=0 data=%h", f / 2, s_addr, s_cwe, s_data, 11'(32'h680 + f / 2), 16'(f / 2)); end
      end else begin
        n_cmp++; if (s_addr !== 11'(32'h200 + f / 2) || s_cwe !== 1'b1) begin
          n_bad++; $display("FAIL fliprd%0d addr=%h cwe=%b exp addr=%h cwe=1", f / 2, s_addr, s_cwe, 11'(32'h200 + f / 2)); end
      end
      do_slot(1'b0);
    end
    flip = 1'b0;
  endtask

  task automatic test_newline_override();
    parse_match = 1'b1;
    flip = 1'b0;
    align_p0();
    pulse_nl();
    do_slot(1'b0); do_slot(1'b0); do_slot(1'b0);
    n_cmp++; if (s_addr !== 11'h200) begin n_bad++; $display("FAIL nlov_rd0 addr=%h exp=200", s_addr); end
    pulse_nl();                       // arrives while the read is being evaluated
    do_slot(1'b0);
    do_slot(1'b0); do_slot(1'b0); do_slot(1'b0);
    n_cmp++; if (s_addr !== 11'h200 || s_cwe !== 1'b1 || active_count !== 7'd0) begin
      n_bad++; $display("FAIL nlov_nowrite addr=%h cwe=%b count=%0d exp addr=200 cwe=1 count=0", s_addr, s_cwe, active_count); end
    do_slot(1'b0);
    do_slot(1'b0); do_slot(1'b0); do_slot(1'b0);
    n_cmp++; if (s_addr !== 11'h600 || s_cwe !== 1'b0 || s_data !== 16'h0000) begin
      n_bad++; $display("FAIL nlov_wr addr=%h cwe=%b data=%h exp addr=600 cwe=0 data=0000", s_addr, s_cwe, s_data); end
    do_slot(1'b0);
    do_slot(1'b0); do_slot(1'b0);
    do_slot(1'b1);                    // NEW_LINE together with the parse SLOT_EN
    n_cmp++; if (s_addr !== prev_addr || s_cwe !== 1'b1 || active_count !== 7'd0 || parse_done !== 1'b0) begin
      n_bad++; $display("FAIL nl_coincident addr=%h cwe=%b count=%0d done=%b exp addr=%h cwe=1 count=0 done=0", s_addr, s_cwe, active_count, parse_done, prev_addr); end
    do_slot(1'b0);
    do_slot(1'b0); do_slot(1'b0); do_slot(1'b0);
    n_cmp++; if (s_addr !== 11'h200 || s_cwe !== 1'b1) begin
      n_bad++; $display("FAIL nl_coincident_next addr=%h cwe=%b exp addr=200 cwe=1", s_addr, s_cwe); end
    do_slot(1'b0);
  endtask

  task automatic test_reset_mid_cpu();
    align_p0();
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b1; bus.cpu_addr = 11'h077; bus.cpu_wdata = 16'h1234;
    do_slot(1'b0); do_slot(1'b0); do_slot(1'b0); do_slot(1'b0);
    n_cmp++; if (s_addr !== 11'h077 || s_cwe !== 1'b0) begin
      n_bad++; $display("FAIL rstcpu_slot addr=%h cwe=%b exp addr=077 cwe=0", s_addr, s_cwe); end
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0; bus.cpu_req = 1'b0;
    ph = 0;
    #1;
    n_cmp++; if (bus.cwe !== 1'b1 || bus.fvram_addr !== 11'h000 || parse_done !== 1'b1) begin
      n_bad++; $display("FAIL rstcpu_state cwe=%b addr=%h done=%b exp cwe=1 addr=000 done=1", bus.cwe, bus.fvram_addr, parse_done); end
    s_addr = 11'h000;
    do_slot(1'b0);
    n_cmp++; if (s_ack !== 1'b0 || s_addr !== 11'h25A) begin
      n_bad++; $display("FAIL rstcpu_noack ack=%b addr=%h exp ack=0 addr=25a", s_ack, s_addr); end
  endtask

  initial begin
    bus.cpu_req   = 1'b0;
    bus.cpu_we    = 1'b0;
    bus.cpu_addr  = 11'h000;
    bus.cpu_wdata = 16'h0000;
    test_reset();
    test_parse_nomatch();
    test_parse_match();
    test_cpu_access();
    test_actrd_wrap();
    test_newline_override();
    test_reset_mid_cpu();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
